// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control sequencer:
// ALU operator encoding, major opcodes, FSM states and datapath mux selects.
package rv_ctrl_pkg;

    localparam int unsigned OPC_W   = 7;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned OPER_W  = 4;

    // ALU operator encoding consumed by the existing datapath
    typedef enum logic [OPER_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_EQ   = 4'd10,
        ALU_NE   = 4'd11,
        ALU_LT   = 4'd12,
        ALU_GE   = 4'd13,
        ALU_LTU  = 4'd14,
        ALU_GEU  = 4'd15
    } operator_t;

    // Major opcodes (IR[6:0])
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_TRAP      = 3'd6
    } state_t;

    // alu_src_a select
    localparam logic [1:0] SRC_A_PC   = 2'b00;
    localparam logic [1:0] SRC_A_RS1  = 2'b01;
    localparam logic [1:0] SRC_A_ZERO = 2'b10;

    // write_from select
    localparam logic [1:0] WF_ALU = 2'b00;
    localparam logic [1:0] WF_MEM = 2'b01;
    localparam logic [1:0] WF_PC4 = 2'b10;

    // pc_select
    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    // True for the nine supported major opcodes plus SYSTEM
    function automatic logic is_known_opcode(input logic [OPC_W-1:0] opc);
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE,
            OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_SYSTEM: is_known_opcode = 1'b1;
            default:                                   is_known_opcode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv_alu_decode.sv
// Combinational IR field decode into ALU operator and operand selects.
// Ports: opc/funct3/funct7 - IR fields; opcode - ALU operator;
//        alu_src_a/alu_src_b - operand selects; illegal - unsupported encoding.
module rv_alu_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opc,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output operator_t  opcode,
    output logic [1:0] alu_src_a,
    output logic       alu_src_b,
    output logic       illegal
);

    // Unknown opcodes fall through to ADD/PC/imm so reset IR (0) yields idle controls
    always_comb begin
        opcode    = ALU_ADD;
        alu_src_a = SRC_A_PC;
        alu_src_b = 1'b0;
        illegal   = 1'b0;
        case (opc)
            OPC_OP: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = 1'b1;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  opcode = ALU_ADD;
                        3'b001:  opcode = ALU_SLL;
                        3'b010:  opcode = ALU_SLT;
                        3'b011:  opcode = ALU_SLTU;
                        3'b100:  opcode = ALU_XOR;
                        3'b101:  opcode = ALU_SRL;
                        3'b110:  opcode = ALU_OR;
                        default: opcode = ALU_AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    opcode = ALU_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    opcode = ALU_SRA;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                alu_src_a = SRC_A_RS1;
                case (funct3)
                    3'b000:  opcode = ALU_ADD;
                    3'b001:  opcode = ALU_SLL;
                    3'b010:  opcode = ALU_SLT;
                    3'b011:  opcode = ALU_SLTU;
                    3'b100:  opcode = ALU_XOR;
                    3'b101:  opcode = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  opcode = ALU_OR;
                    default: opcode = ALU_AND;
                endcase
            end
            OPC_LUI:   alu_src_a = SRC_A_ZERO;
            OPC_AUIPC: alu_src_a = SRC_A_PC;
            OPC_LOAD, OPC_STORE, OPC_JALR: alu_src_a = SRC_A_RS1;
            OPC_JAL, OPC_SYSTEM: alu_src_a = SRC_A_PC;
            OPC_BRANCH: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = 1'b1;
                case (funct3)
                    3'b000:  opcode = ALU_EQ;
                    3'b001:  opcode = ALU_NE;
                    3'b100:  opcode = ALU_LT;
                    3'b101:  opcode = ALU_GE;
                    3'b110:  opcode = ALU_LTU;
                    3'b111:  opcode = ALU_GEU;
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: registered IR, fetch/decode/execute/
// mem/writeback FSM, memory handshakes with ack-wait timeout, sticky traps.
// Ports: clk, rst_n; start (IDLE -> FETCH); instruction/imem_ack/imem_req
// (fetch); dmem_ack/dmem_read/dmem_write (data); zeros/flag_lt/flag_ltu
// (branch flags); opcode, alu_src_a/b, reg_write, write_from, pc_write,
// pc_select (datapath controls); busy; illegal_instr, timeout_err (sticky).
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned XLEN           = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] instruction,
    input  logic            imem_ack,
    input  logic            dmem_ack,
    input  logic            zeros,
    input  logic            flag_lt,
    input  logic            flag_ltu,
    output logic            imem_req,
    output logic            dmem_read,
    output logic            dmem_write,
    output operator_t       opcode,
    output logic [1:0]      alu_src_a,
    output logic            alu_src_b,
    output logic            reg_write,
    output logic [1:0]      write_from,
    output logic            pc_write,
    output logic [1:0]      pc_select,
    output logic            busy,
    output logic            illegal_instr,
    output logic            timeout_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    // Counter value in the last tolerated wait cycle; the next miss would reach the limit
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    if (XLEN != 32) begin : g_xlen_check
        $error("rv_multicycle_ctrl: XLEN must be 32");
    end

    state_t            state, state_d;
    logic [XLEN-1:0]   ir, ir_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              illegal_q, illegal_d;
    logic              timeout_q, timeout_d;

    logic [6:0] opc;
    logic [2:0] funct3;
    logic       dec_illegal;
    logic       wait_expired;
    logic       branch_taken;
    logic       ir_unused;

    assign opc          = ir[6:0];
    assign funct3       = ir[14:12];
    assign wait_expired = TIMEOUT_EN && (cnt == CNT_LAST);
    // Register/immediate fields belong to the datapath, not the sequencer
    assign ir_unused    = ^{ir[24:15], ir[11:7]};

    rv_alu_decode u_alu_decode (
        .opc       (opc),
        .funct3    (funct3),
        .funct7    (ir[31:25]),
        .opcode    (opcode),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .illegal   (dec_illegal)
    );

    // Branch condition from this cycle's ALU flags
    always_comb begin
        case (funct3)
            3'b000:  branch_taken = zeros;
            3'b001:  branch_taken = !zeros;
            3'b100:  branch_taken = flag_lt;
            3'b101:  branch_taken = !flag_lt;
            3'b110:  branch_taken = flag_ltu;
            3'b111:  branch_taken = !flag_ltu;
            default: branch_taken = 1'b0;
        endcase
    end

    // State, IR, wait counter and sticky trap flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ir        <= '0;
            cnt       <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_d;
            ir        <= ir_d;
            cnt       <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state;
        ir_d      = ir;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state)
            S_IDLE: if (start) state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = instruction;
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_DECODE: begin
                if (!is_known_opcode(opc)) begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end else if (opc == OPC_SYSTEM) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (dec_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    case (opc)
                        OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: state_d = S_WRITEBACK;
                        OPC_LOAD, OPC_STORE:                    state_d = S_MEM;
                        OPC_BRANCH, OPC_JAL, OPC_JALR:          state_d = S_FETCH;
                        default: begin
                            illegal_d = 1'b1;
                            state_d   = S_TRAP;
                        end
                    endcase
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_d = (opc == OPC_LOAD) ? S_WRITEBACK : S_FETCH;
                end else if (wait_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_WRITEBACK: state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_IDLE;
        endcase

        // Wait counter restarts on every state change, counts missed acks otherwise
        if (state_d != state) begin
            cnt_d = '0;
        end else if (state == S_FETCH || state == S_MEM) begin
            cnt_d = cnt + 1'b1;
        end else begin
            cnt_d = cnt;
        end
    end

    // Output decode
    always_comb begin
        imem_req   = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        reg_write  = 1'b0;
        write_from = WF_ALU;
        pc_write   = 1'b0;
        pc_select  = PC_PLUS4;
        busy       = (state != S_IDLE) && (state != S_TRAP);
        case (state)
            S_FETCH: imem_req = 1'b1;
            S_EXECUTE: begin
                if (!dec_illegal) begin
                    case (opc)
                        OPC_BRANCH: begin
                            pc_write  = 1'b1;
                            pc_select = branch_taken ? PC_IMM : PC_PLUS4;
                        end
                        OPC_JAL: begin
                            reg_write  = 1'b1;
                            write_from = WF_PC4;
                            pc_write   = 1'b1;
                            pc_select  = PC_IMM;
                        end
                        OPC_JALR: begin
                            reg_write  = 1'b1;
                            write_from = WF_PC4;
                            pc_write   = 1'b1;
                            pc_select  = PC_ALU;
                        end
                        default: ;
                    endcase
                end
            end
            S_MEM: begin
                if (opc == OPC_LOAD) begin
                    dmem_read = 1'b1;
                end else begin
                    dmem_write = 1'b1;
                    pc_write   = dmem_ack;
                end
            end
            S_WRITEBACK: begin
                reg_write  = 1'b1;
                write_from = (opc == OPC_LOAD) ? WF_MEM : WF_ALU;
                pc_write   = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal_instr = illegal_q;
    assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: table of per-instruction control
// expectations plus hand-written wait, timeout, trap and reset sequences.
module tb_rv_multicycle_ctrl;
    import rv_ctrl_pkg::*;

    localparam int unsigned T_CYC = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] instruction;
    logic        imem_ack;
    logic        dmem_ack;
    logic        zeros;
    logic        flag_lt;
    logic        flag_ltu;
    logic        imem_req;
    logic        dmem_read;
    logic        dmem_write;
    operator_t   opcode;
    logic [1:0]  alu_src_a;
    logic        alu_src_b;
    logic        reg_write;
    logic [1:0]  write_from;
    logic        pc_write;
    logic [1:0]  pc_select;
    logic        busy;
    logic        illegal_instr;
    logic        timeout_err;

    rv_multicycle_ctrl #(.TIMEOUT_CYCLES(T_CYC), .XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .instruction   (instruction),
        .imem_ack      (imem_ack),
        .dmem_ack      (dmem_ack),
        .zeros         (zeros),
        .flag_lt       (flag_lt),
        .flag_ltu      (flag_ltu),
        .imem_req      (imem_req),
        .dmem_read     (dmem_read),
        .dmem_write    (dmem_write),
        .opcode        (opcode),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .reg_write     (reg_write),
        .write_from    (write_from),
        .pc_write      (pc_write),
        .pc_select     (pc_select),
        .busy          (busy),
        .illegal_instr (illegal_instr),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic        z;
        logic        lt;
        logic        ltu;
        logic [3:0]  cycles;   // cycle (from FETCH = 1) holding the checked strobes
        logic        rw;
        logic [1:0]  wf;
        logic        pw;
        logic [1:0]  ps;
        operator_t   op;
        logic [1:0]  sa;
        logic        sb;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];
    vec_t v;
    int   n_vec;
    int   n_bad;
    int   ncyc;
    int   rd_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        start       = 1'b0;
        imem_ack    = 1'b0;
        dmem_ack    = 1'b0;
        instruction = 32'd0;
        zeros       = 1'b0;
        flag_lt     = 1'b0;
        flag_ltu    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Leaves the bench 1 time unit into cycle 1 (the first FETCH cycle)
    task automatic launch(input logic [31:0] instr, input logic iack);
        instruction = instr;
        imem_ack    = iack;
        start       = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        //          instr         z     lt    ltu   cyc   rw    wf      pw    ps        op        sa          sb
        vecs[0]  = '{32'h002081B3, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, WF_ALU, 1'b1, PC_PLUS4, ALU_ADD,  SRC_A_RS1,  1'b1};
        vecs[1]  = '{32'h402081B3, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, WF_ALU, 1'b1, PC_PLUS4, ALU_SUB,  SRC_A_RS1,  1'b1};
        vecs[2]  = '{32'h4020D1B3, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, WF_ALU, 1'b1, PC_PLUS4, ALU_SRA,  SRC_A_RS1,  1'b1};
        vecs[3]  = '{32'h0020E1B3, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, WF_ALU, 1'b1, PC_PLUS4, ALU_OR,   SRC_A_RS1,  1'b1};
        vecs[4]  = '{32'h00508193, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, WF_ALU, 1'b1, PC_PLUS4, ALU_ADD,  SRC_A_RS1,  1'b0};
        vecs[5]  = '{32'h4020D193, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, WF_ALU, 1'b1, PC_PLUS4, ALU_SRA,  SRC_A_RS1,  1'b0};
        vecs[6]  = '{32'h123451B7, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, WF_ALU, 1'b1, PC_PLUS4, ALU_ADD,  SRC_A_ZERO, 1'b0};
        vecs[7]  = '{32'h00001197, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, WF_ALU, 1'b1, PC_PLUS4, ALU_ADD,  SRC_A_PC,   1'b0};
        vecs[8]  = '{32'h0000A183, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, WF_MEM, 1'b1, PC_PLUS4, ALU_ADD,  SRC_A_RS1,  1'b0};
        vecs[9]  = '{32'h0020A023, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, WF_ALU, 1'b1, PC_PLUS4, ALU_ADD,  SRC_A_RS1,  1'b0};
        vecs[10] = '{32'h00208463, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, WF_ALU, 1'b1, PC_IMM,   ALU_EQ,   SRC_A_RS1,  1'b1};
        vecs[11] = '{32'h00208463, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, WF_ALU, 1'b1, PC_PLUS4, ALU_EQ,   SRC_A_RS1,  1'b1};
        vecs[12] = '{32'h00209463, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, WF_ALU, 1'b1, PC_IMM,   ALU_NE,   SRC_A_RS1,  1'b1};
        vecs[13] = '{32'h0020C463, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, WF_ALU, 1'b1, PC_IMM,   ALU_LT,   SRC_A_RS1,  1'b1};
        vecs[14] = '{32'h0020D463, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, WF_ALU, 1'b1, PC_PLUS4, ALU_GE,   SRC_A_RS1,  1'b1};
        vecs[15] = '{32'h0020E463, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, WF_ALU, 1'b1, PC_PLUS4, ALU_LTU,  SRC_A_RS1,  1'b1};
        vecs[16] = '{32'h0020F463, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, WF_ALU, 1'b1, PC_IMM,   ALU_GEU,  SRC_A_RS1,  1'b1};
        vecs[17] = '{32'h008000EF, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, WF_PC4, 1'b1, PC_IMM,   ALU_ADD,  SRC_A_PC,   1'b0};
        vecs[18] = '{32'h000080E7, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, WF_PC4, 1'b1, PC_ALU,   ALU_ADD,  SRC_A_RS1,  1'b0};

        // Reset values appear without a clock edge
        rst_n = 1'b1; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        instruction = 32'd0; zeros = 1'b0; flag_lt = 1'b0; flag_ltu = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_strobes", 32'({imem_req, dmem_read, dmem_write, reg_write, pc_write,
                                busy, illegal_instr, timeout_err}), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'(ALU_ADD));
        chk("rst_selects", 32'({alu_src_a, alu_src_b, write_from, pc_select}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick();
        chk("idle_no_start", 32'({busy, imem_req}), 32'd0);

        // Table: zero-wait acks, strobes land on the expected cycle only
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            ncyc = int'(v.cycles);
            apply_reset();
            zeros    = v.z;
            flag_lt  = v.lt;
            flag_ltu = v.ltu;
            dmem_ack = 1'b1;
            launch(v.instr, 1'b1);
            for (int c = 1; c <= ncyc + 1; c++) begin
                #1;
                if (c < ncyc) begin
                    chk($sformatf("v%0d_c%0d_early", i, c), 32'({reg_write, pc_write}), 32'd0);
                end else if (c == ncyc) begin
                    chk($sformatf("v%0d_reg_write", i), 32'(reg_write), 32'(v.rw));
                    chk($sformatf("v%0d_write_from", i), 32'(write_from), 32'(v.wf));
                    chk($sformatf("v%0d_pc_write", i), 32'(pc_write), 32'(v.pw));
                    chk($sformatf("v%0d_pc_select", i), 32'(pc_select), 32'(v.ps));
                    chk($sformatf("v%0d_opcode", i), 32'(opcode), 32'(v.op));
                    chk($sformatf("v%0d_src_a", i), 32'(alu_src_a), 32'(v.sa));
                    chk($sformatf("v%0d_src_b", i), 32'(alu_src_b), 32'(v.sb));
                end else begin
                    chk($sformatf("v%0d_refetch", i),
                        32'({imem_req, reg_write, pc_write, busy}), 32'(4'b1001));
                end
                tick();
            end
        end

        // LW with 3 wait cycles: read held 4 cycles, ack on counter's last tolerated cycle
        apply_reset();
        launch(32'h0000A183, 1'b1);
        rd_cnt = 0;
        for (int c = 1; c <= 9; c++) begin
            dmem_ack = (c == 7);
            #1;
            if (dmem_read) rd_cnt++;
            if (c == 7) chk("lw_wait_ack_cycle", 32'({reg_write, timeout_err, dmem_read}), 32'(3'b001));
            if (c == 8) chk("lw_wait_wb", 32'({reg_write, write_from, pc_write, pc_select}), 32'(6'b101100));
            if (c == 9) chk("lw_wait_refetch", 32'({imem_req, dmem_read}), 32'(2'b10));
            tick();
        end
        chk("lw_wait_read_cycles", 32'(rd_cnt), 32'd4);

        // SW with one wait: pc_write only in the ack cycle
        apply_reset();
        launch(32'h0020A023, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            dmem_ack = (c == 5);
            #1;
            if (c == 4) chk("sw_wait", 32'({dmem_write, pc_write, reg_write}), 32'(3'b100));
            if (c == 5) chk("sw_ack", 32'({dmem_write, pc_write, pc_select, reg_write}), 32'(5'b11000));
            if (c == 6) chk("sw_done", 32'({dmem_write, imem_req}), 32'(2'b01));
            tick();
        end

        // Fetch timeout: imem_ack never comes
        apply_reset();
        launch(32'h002081B3, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            #1;
            if (c <= 4) chk($sformatf("fto_c%0d_wait", c), 32'({busy, imem_req, timeout_err}), 32'(3'b110));
            else        chk($sformatf("fto_c%0d_trap", c), 32'({busy, imem_req, timeout_err}), 32'(3'b001));
            tick();
        end

        // Ack in the limit cycle beats the timeout
        apply_reset();
        launch(32'h002081B3, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            imem_ack = (c >= 4);
            #1;
            if (c == 5) chk("ack_wins_decode", 32'({busy, imem_req, timeout_err}), 32'(3'b100));
            if (c == 7) chk("ack_wins_wb", 32'({reg_write, pc_write, timeout_err}), 32'(3'b110));
            tick();
        end

        // Memory timeout on a load
        apply_reset();
        launch(32'h0000A183, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            #1;
            if (c == 7) chk("mto_wait", 32'({busy, dmem_read, timeout_err}), 32'(3'b110));
            if (c == 8) chk("mto_trap", 32'({busy, dmem_read, timeout_err}), 32'(3'b001));
            tick();
        end

        // Reset mid-MEM clears outputs immediately
        apply_reset();
        launch(32'h0000A183, 1'b1);
        for (int c = 1; c <= 4; c++) tick();
        #1;
        chk("mid_mem_before", 32'({dmem_read, busy, alu_src_a}), 32'(4'b1101));
        rst_n = 1'b0;
        #1;
        chk("mid_mem_reset", 32'({dmem_read, busy, alu_src_a, alu_src_b, illegal_instr, timeout_err}), 32'd0);
        chk("mid_mem_reset_op", 32'(opcode), 32'(ALU_ADD));
        @(negedge clk);
        rst_n = 1'b1;

        // All-zero instruction traps after DECODE, start ignored, reset clears
        apply_reset();
        launch(32'h00000000, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            if (c >= 3) start = 1'b1;
            #1;
            if (c == 2) chk("ill0_decode", 32'({busy, illegal_instr}), 32'(2'b10));
            if (c == 3) chk("ill0_trap", 32'({illegal_instr, busy, imem_req}), 32'(3'b100));
            if (c == 8) chk("ill0_held", 32'({illegal_instr, busy, imem_req}), 32'(3'b100));
            tick();
        end
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("ill0_reset", 32'({illegal_instr, busy}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Funct-level illegal encodings trap from EXECUTE without strobes
        apply_reset();
        launch(32'h202081B3, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            #1;
            if (c == 3) chk("ill_f7_exec", 32'({reg_write, pc_write, illegal_instr}), 32'd0);
            if (c == 4) chk("ill_f7_trap", 32'({illegal_instr, busy}), 32'(2'b10));
            tick();
        end
        apply_reset();
        zeros = 1'b1;
        launch(32'h0020A463, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            #1;
            if (c == 3) chk("ill_br_exec", 32'({pc_write, illegal_instr}), 32'd0);
            if (c == 4) chk("ill_br_trap", 32'({illegal_instr, busy}), 32'(2'b10));
            tick();
        end

        // SYSTEM halts back to IDLE
        apply_reset();
        launch(32'h00000073, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            #1;
            if (c == 2) chk("sys_decode", 32'(busy), 32'd1);
            if (c >= 3) chk($sformatf("sys_c%0d_idle", c), 32'({busy, imem_req, illegal_instr}), 32'd0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rv_multicycle_ctrl.md
# rv_multicycle_ctrl

Multi-cycle control sequencer for the RV32I core. It replaces the purely combinational decode path with a registered instruction register and a state machine. The machine sequences fetch, decode, execute, memory and writeback, and handshakes with instruction and data memories. It sits between the fetch/memory interfaces and the existing ALU/register-file datapath, driving the same operator and mux-select encodings that datapath already consumes.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum wait cycles for a memory ack. 0 disables the timeout.
- `XLEN`, 32: instruction/IR width. Only 32 is legal; an elaboration assertion rejects anything else.

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  leave IDLE and begin fetching
- `instruction`  in  XLEN  instruction memory read data, valid when `imem_ack`=1
- `imem_ack`  in  1  instruction memory completes request
- `dmem_ack`  in  1  data memory completes load/store
- `zeros`, `flag_lt`, `flag_ltu`  in  1 each  ALU compare flags for the current EXECUTE
- `imem_req`  out  1  instruction fetch request
- `dmem_read`, `dmem_write`  out  1 each  data memory request
- `opcode`  out  operator_t  ALU operation
- `alu_src_a`  out  2  00 PC, 01 rs1, 10 zero
- `alu_src_b`  out  1  1 rs2, 0 immediate
- `reg_write`  out  1  register-file write strobe
- `write_from`  out  2  00 ALU, 01 memory, 10 PC+4
- `pc_write`  out  1  PC update strobe
- `pc_select`  out  2  00 PC+4, 01 PC+imm, 10 ALU result (rs1+imm, bit0 cleared by datapath)
- `busy`  out  1  state ≠ IDLE and ≠ TRAP
- `illegal_instr`, `timeout_err`  out  1 each  sticky trap causes

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
- IDLE:
  - With `start`=1, go to FETCH.
- FETCH:
  - Assert `imem_req`.
  - On `imem_ack`, capture `instruction` into IR and go to DECODE.
- DECODE:
  - Classify IR[6:0].
  - Unknown opcode: go to TRAP and set `illegal_instr`.
  - SYSTEM (1110011): go to IDLE (halt).
  - Otherwise go to EXECUTE.
- EXECUTE (all ALU controls are decoded from IR, so they are stable for the whole instruction):
  - OP (0110011): operator decoded from funct3 plus funct7. funct7=0100000 is valid only for ADD→SUB and SRL→SRA; any other funct7 traps illegal. Sources 01/1. Next state WRITEBACK.
  - OP-IMM (0010011): operator from funct3. SRAI when funct3=101 and IR[30]=1. Sources 01/0. Next state WRITEBACK.
  - LUI (0110111): ADD, sources 10/0. AUIPC (0010111): ADD, sources 00/0. Both go to WRITEBACK.
  - LOAD/STORE: ADD, sources 01/0. Next state MEM.
  - BRANCH:
    - Operators: EQ, NE, LT, GE, LTU, GEU. funct3 010/011 traps illegal.
    - Sources 01/1.
    - Taken = zeros (BEQ), !zeros (BNE), flag_lt (BLT), !flag_lt (BGE), flag_ltu (BLTU), !flag_ltu (BGEU).
    - `pc_write`=1; `pc_select`=01 if taken, else 00. Next state FETCH.
  - JAL: sources 00/0. JALR: sources 01/0. Both assert `reg_write`, `write_from`=10 and `pc_write` in EXECUTE, with `pc_select` 01 (JAL) or 10 (JALR). Next state FETCH.
- MEM:
  - Hold `dmem_read` (load) or `dmem_write` (store) until `dmem_ack`.
  - Load then goes to WRITEBACK. Store asserts `pc_write` with `pc_select`=00 in its ack cycle and goes to FETCH.
- WRITEBACK:
  - `reg_write`=1; `write_from`=01 for loads, 00 otherwise.
  - `pc_write`=1 with `pc_select`=00. Next state FETCH.
- TRAP:
  - All strobes 0. Remains in TRAP until `rst_n` is asserted low.
- Timeout:
  - A wait counter clears on entry to FETCH/MEM and increments each cycle without ack.
  - When it reaches `TIMEOUT_CYCLES` (nonzero), go to TRAP and set `timeout_err`.
  - An ack in the same cycle the counter reaches `TIMEOUT_CYCLES` wins.

## Timing
- Every output is a function of registered state, IR and counter, except the branch `pc_select`, which also uses the same-cycle flags.
- Cycle counts with zero-wait acks:
  - OP/OP-IMM/LUI/AUIPC: 4
  - Load: 5
  - Store: 4
  - Branch, JAL, JALR: 3
- Each wait cycle adds one cycle.
- Strobes (`pc_write`, `reg_write`) are single-cycle pulses.
- Memory requests hold high until ack, inclusive of the ack cycle.
- Reset (asynchronous, any state, including mid-MEM):
  - State IDLE, IR 0, counter 0.
  - All strobes and requests 0, `opcode`=ADD, all selects 0, error flags 0.
  - Outputs take these values immediately, not at the next edge.
- `start` is ignored outside IDLE.

## Structure
- Package `rv_ctrl_pkg` holds:
  - `operator_t`, the existing encoding, unchanged.
  - Opcode localparams for all nine major opcodes plus SYSTEM.
  - The state enum.
  - The `alu_src_a`, `write_from` and `pc_select` encoding constants.
- Sub-module `rv_alu_decode` is the combinational IR → {opcode, alu_src_a, alu_src_b, illegal} decode.
- The FSM, counter and IR stay in the top module.

## Test plan
- ADD 0x002081B3, `imem_ack` immediate: `reg_write` pulses in cycle 4 with `opcode`=ADD, src 01/1, `write_from`=00; `pc_write`/00 in the same cycle.
- LW 0x0000A183, `dmem_ack` after 3 waits: `dmem_read` high 4 cycles; the next cycle has `reg_write`=1 with `write_from`=01.
- BEQ 0x00208463: with `zeros`=1, `pc_write`=1 and `pc_select`=01 in cycle 3. With `zeros`=0, `pc_select`=00.
- JALR 0x000080E7: in cycle 3, `reg_write`=1, `write_from`=10, `pc_select`=10, src 01/0.
- Instruction 0x00000000: TRAP after DECODE, `illegal_instr`=1, `busy`=0, held until reset.
- `TIMEOUT_CYCLES`=4 and `imem_ack` stuck low: TRAP with `timeout_err`=1 exactly 4 cycles after FETCH entry. A later `rst_n` pulse mid-MEM clears everything immediately.
